// File: rtl/irom_prefetch_queue.sv
// Instruction-fetch front end: word fetches from instruction ROM feed an
// 8-byte circular queue that presents the next three opcode bytes and the PC.
module irom_prefetch_queue #(
  parameter int ADDR_W = 16,
  parameter int QDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_wr,
  input  logic [ADDR_W-1:0] pc_wr_addr,
  input  logic              consume,
  input  logic [1:0]        consume_cnt,
  output logic              istb_o,
  output logic [ADDR_W-1:0] iadr_o,
  input  logic              iack_i,
  input  logic [31:0]       idat_i,
  output logic [7:0]        op1,
  output logic [7:0]        op2,
  output logic [7:0]        op3,
  output logic [1:0]        avail,
  output logic [ADDR_W-1:0] pc,
  output logic              irom_out_of_rst
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DISCARD} fstate_t;

  fstate_t           state_reg, state_next;
  logic [PW-1:0]     head_reg, tail_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] iadr_reg, iadr_next;
  logic [ADDR_W-1:0] tgt_reg, tgt_next;
  logic [1:0]        skip_reg, skip_next;
  logic              oor_reg;
  logic [7:0]        q_mem [QDEPTH];

  logic              ack_ok;
  logic [2:0]        enq_cnt;
  logic [1:0]        cons_cnt;
  logic              space_ok;
  logic [ADDR_W-1:0] redir_word;
  logic [PW-1:0]     wr_idx [4];
  logic [3:0]        wr_en;
  logic [7:0]        op_byte [3];

  // A response is only kept when it answers a live request and no redirect
  // is flushing the queue in the same cycle.
  assign ack_ok     = (state_reg == F_REQ) && iack_i && !pc_wr;
  assign enq_cnt    = ack_ok ? (3'd4 - {1'b0, skip_reg}) : 3'd0;
  assign cons_cnt   = (consume && !pc_wr) ? consume_cnt : 2'd0;
  assign count_next = pc_wr ? '0 : (count_reg + CW'(enq_cnt) - CW'(cons_cnt));
  assign space_ok   = (count_next <= CW'(QDEPTH - 4));
  assign redir_word = {pc_wr_addr[ADDR_W-1:2], 2'b00};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr
      assign wr_idx[gi] = tail_reg + PW'(gi) - PW'(skip_reg);
      assign wr_en[gi]  = ack_ok && (2'(gi) >= skip_reg);
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign op_byte[gi] = (count_reg > CW'(gi)) ? q_mem[PW'(head_reg + PW'(gi))] : 8'h00;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    iadr_next  = iadr_reg;
    tgt_next   = tgt_reg;
    skip_next  = skip_reg;
    case (state_reg)
      F_IDLE: begin
        if (pc_wr) begin
          state_next = F_REQ;
          iadr_next  = redir_word;
          skip_next  = pc_wr_addr[1:0];
        end else if (space_ok) begin
          state_next = F_REQ;
        end
      end
      F_REQ: begin
        if (pc_wr) begin
          skip_next = pc_wr_addr[1:0];
          if (iack_i) begin
            iadr_next = redir_word;
          end else begin
            // address must stay put until the ROM answers the old request
            state_next = F_DISCARD;
            tgt_next   = redir_word;
          end
        end else if (iack_i) begin
          iadr_next  = iadr_reg + ADDR_W'(4);
          skip_next  = 2'd0;
          state_next = space_ok ? F_REQ : F_IDLE;
        end
      end
      F_DISCARD: begin
        if (pc_wr) begin
          tgt_next  = redir_word;
          skip_next = pc_wr_addr[1:0];
        end
        if (iack_i) begin
          state_next = F_REQ;
          iadr_next  = pc_wr ? redir_word : tgt_reg;
        end
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= F_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      pc_reg    <= '0;
      iadr_reg  <= '0;
      tgt_reg   <= '0;
      skip_reg  <= 2'd0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= pc_wr ? tail_reg : (head_reg + PW'(cons_cnt));
      tail_reg  <= tail_reg + PW'(enq_cnt);
      count_reg <= count_next;
      pc_reg    <= pc_wr ? pc_wr_addr : (pc_reg + ADDR_W'(cons_cnt));
      iadr_reg  <= iadr_next;
      tgt_reg   <= tgt_next;
      skip_reg  <= skip_next;
      if (ack_ok) oor_reg <= 1'b1;
    end
  end

  // Queue storage needs no reset: bytes beyond count are masked on read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) q_mem[wr_idx[k]] <= idat_i[8*k +: 8];
    end
  end

  assign istb_o          = (state_reg != F_IDLE);
  assign iadr_o          = iadr_reg;
  assign op1             = op_byte[0];
  assign op2             = op_byte[1];
  assign op3             = op_byte[2];
  assign avail           = (count_reg >= CW'(3)) ? 2'd3 : count_reg[1:0];
  assign pc              = pc_reg;
  assign irom_out_of_rst = oor_reg;
endmodule

// File: tb/tb_irom_prefetch_queue.sv
// Directed bench for irom_prefetch_queue: a behavioural ROM answers requests
// with a configurable wait, outputs are checked on the falling edge.
module tb_irom_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wr;
  logic [15:0] pc_wr_addr;
  logic        consume;
  logic [1:0]  consume_cnt;
  logic        istb_o;
  logic [15:0] iadr_o;
  logic        iack_i;
  logic [31:0] idat_i;
  logic [7:0]  op1, op2, op3;
  logic [1:0]  avail;
  logic [15:0] pc;
  logic        irom_out_of_rst;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  logic override_zero = 1'b0;
  logic force_ack     = 1'b0;

  always #5 clk = ~clk;

  irom_prefetch_queue #(.ADDR_W(16), .QDEPTH(8)) dut (
    .clk(clk), .rst(rst), .pc_wr(pc_wr), .pc_wr_addr(pc_wr_addr),
    .consume(consume), .consume_cnt(consume_cnt),
    .istb_o(istb_o), .iadr_o(iadr_o), .iack_i(iack_i), .idat_i(idat_i),
    .op1(op1), .op2(op2), .op3(op3), .avail(avail), .pc(pc),
    .irom_out_of_rst(irom_out_of_rst)
  );

  // ROM content: byte at address a
  function automatic logic [7:0] rb(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h80;
  endfunction

  function automatic logic [31:0] rw(input logic [15:0] a);
    if (override_zero && a == 16'h0000) return 32'h33221100;
    return {rb(a + 16'd3), rb(a + 16'd2), rb(a + 16'd1), rb(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs (including the ROM's answer), clock, return on negedge.
  task automatic step(input logic wr, input logic [15:0] a, input logic c, input logic [1:0] n);
    pc_wr = wr; pc_wr_addr = a; consume = c; consume_cnt = n;
    if (c && !wr) chk("consume_legal", {31'd0, (n <= avail)}, 32'd1);
    iack_i = 1'b0; idat_i = 32'h0;
    if (force_ack) begin
      iack_i = 1'b1; idat_i = rw(iadr_o);
    end else if (istb_o) begin
      if (wait_cnt >= ack_delay) begin
        iack_i = 1'b1; idat_i = rw(iadr_o); wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    $display("cyc wr=%0b a=%04h c=%0b n=%0d ack=%0b | stb=%0b adr=%04h pc=%04h op=%02h %02h %02h av=%0d oor=%0b",
             wr, a, c, n, iack_i, istb_o, iadr_o, pc, op1, op2, op3, avail, irom_out_of_rst);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 2'd0);
  endtask

  typedef struct {
    logic        c;
    logic [1:0]  n;
    logic [15:0] pc;
    logic [7:0]  o1, o2, o3;
    logic [1:0]  av;
    logic        stb;
    logic [15:0] adr;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 2'd1, 16'h0001, 8'h81, 8'h82, 8'h83, 2'd3, 1'b0, 16'h0008};
    tbl[1] = '{1'b1, 2'd2, 16'h0003, 8'h83, 8'h84, 8'h85, 2'd3, 1'b0, 16'h0008};
    tbl[2] = '{1'b1, 2'd3, 16'h0006, 8'h86, 8'h87, 8'h00, 2'd2, 1'b1, 16'h0008};
    tbl[3] = '{1'b0, 2'd0, 16'h0006, 8'h86, 8'h87, 8'h88, 2'd3, 1'b0, 16'h000C};
    tbl[4] = '{1'b1, 2'd3, 16'h0009, 8'h89, 8'h8A, 8'h8B, 2'd3, 1'b1, 16'h000C};
    tbl[5] = '{1'b1, 2'd1, 16'h000A, 8'h8A, 8'h8B, 8'h8C, 2'd3, 1'b0, 16'h0010};
    tbl[6] = '{1'b0, 2'd0, 16'h000A, 8'h8A, 8'h8B, 8'h8C, 2'd3, 1'b0, 16'h0010};

    rst = 1'b1; pc_wr = 1'b0; pc_wr_addr = 16'h0; consume = 1'b0; consume_cnt = 2'd0;
    iack_i = 1'b0; idat_i = 32'h0;
    @(negedge clk);

    // reset state, then first word with the special 0x33221100 content
    override_zero = 1'b1;
    idle(); idle();
    chk("rst_istb", istb_o, 0); chk("rst_iadr", iadr_o, 0); chk("rst_avail", avail, 0);
    chk("rst_pc", pc, 0); chk("rst_op1", op1, 0); chk("rst_op2", op2, 0);
    chk("rst_op3", op3, 0); chk("rst_oor", irom_out_of_rst, 0);
    rst = 1'b0;
    idle();
    chk("first_istb", istb_o, 1); chk("first_iadr", iadr_o, 16'h0000);
    chk("first_oor_low", irom_out_of_rst, 0);
    idle();
    chk("first_op1", op1, 8'h00); chk("first_op2", op2, 8'h11); chk("first_op3", op3, 8'h22);
    chk("first_avail", avail, 3); chk("first_pc", pc, 0);
    chk("first_oor", irom_out_of_rst, 1); chk("second_iadr", iadr_o, 16'h0004);

    // restart with plain ROM content, fill the queue, then stream consumes
    override_zero = 1'b0;
    rst = 1'b1; idle(); rst = 1'b0;
    idle(); idle(); idle(); idle();
    chk("fill_avail", avail, 3); chk("fill_istb", istb_o, 0); chk("fill_iadr", iadr_o, 16'h0008);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 16'h0, tbl[i].c, tbl[i].n);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_op1", i), op1, tbl[i].o1);
      chk($sformatf("v%0d_op2", i), op2, tbl[i].o2);
      chk($sformatf("v%0d_op3", i), op3, tbl[i].o3);
      chk($sformatf("v%0d_avail", i), avail, tbl[i].av);
      chk($sformatf("v%0d_istb", i), istb_o, tbl[i].stb);
      chk($sformatf("v%0d_iadr", i), iadr_o, tbl[i].adr);
    end

    // unaligned redirect while idle
    step(1'b1, 16'h0102, 1'b0, 2'd0);
    chk("rd1_istb", istb_o, 1); chk("rd1_iadr", iadr_o, 16'h0100);
    chk("rd1_pc", pc, 16'h0102); chk("rd1_avail", avail, 0);
    idle();
    chk("rd1_op1", op1, 8'h83); chk("rd1_op2", op2, 8'h82); chk("rd1_op3", op3, 8'h00);
    chk("rd1_avail2", avail, 2); chk("rd1_iadr2", iadr_o, 16'h0104);

    // redirect during pending request; second redirect while discarding
    step(1'b1, 16'h0010, 1'b0, 2'd0);
    chk("rd2_iadr", iadr_o, 16'h0010); chk("rd2_avail", avail, 0); chk("rd2_pc", pc, 16'h0010);
    ack_delay = 3;
    idle();
    chk("pend_istb", istb_o, 1); chk("pend_iadr", iadr_o, 16'h0010);
    step(1'b1, 16'h0300, 1'b0, 2'd0);
    chk("disc_iadr", iadr_o, 16'h0010); chk("disc_pc", pc, 16'h0300); chk("disc_istb", istb_o, 1);
    step(1'b1, 16'h0200, 1'b0, 2'd0);
    chk("disc2_iadr", iadr_o, 16'h0010); chk("disc2_pc", pc, 16'h0200);
    idle();
    chk("disc_done_iadr", iadr_o, 16'h0200); chk("disc_done_avail", avail, 0);
    ack_delay = 0;
    idle();
    chk("rd3_op1", op1, 8'h82); chk("rd3_op2", op2, 8'h83); chk("rd3_op3", op3, 8'h80);
    chk("rd3_avail", avail, 3); chk("rd3_pc", pc, 16'h0200); chk("rd3_iadr", iadr_o, 16'h0204);

    // full queue with a stalled decoder
    idle();
    chk("full_istb", istb_o, 0); chk("full_iadr", iadr_o, 16'h0208);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("stall%0d_istb", i), istb_o, 0);
    end
    step(1'b0, 16'h0, 1'b1, 2'd3);
    chk("c3_istb", istb_o, 0); chk("c3_pc", pc, 16'h0203);
    step(1'b0, 16'h0, 1'b1, 2'd1);
    chk("c1_istb", istb_o, 1); chk("c1_iadr", iadr_o, 16'h0208);
    chk("c1_pc", pc, 16'h0204); chk("c1_op1", op1, 8'h86);

    // address and pc wrap-around
    step(1'b1, 16'hFFFE, 1'b0, 2'd0);
    chk("wr_iadr", iadr_o, 16'hFFFC); chk("wr_pc", pc, 16'hFFFE); chk("wr_avail", avail, 0);
    idle();
    chk("wr_op1", op1, 8'h81); chk("wr_op2", op2, 8'h80); chk("wr_avail2", avail, 2);
    chk("wr_iadr2", iadr_o, 16'h0000);
    step(1'b0, 16'h0, 1'b1, 2'd2);
    chk("wr_pc2", pc, 16'h0000); chk("wr_op1b", op1, 8'h80); chk("wr_op2b", op2, 8'h81);
    chk("wr_op3b", op3, 8'h82); chk("wr_avail3", avail, 3); chk("wr_iadr3", iadr_o, 16'h0004);

    // reset during an outstanding request; a stray ack afterwards is ignored
    ack_delay = 3;
    idle();
    rst = 1'b1; idle(); rst = 1'b0;
    chk("mrst_istb", istb_o, 0); chk("mrst_avail", avail, 0); chk("mrst_pc", pc, 0);
    chk("mrst_iadr", iadr_o, 0); chk("mrst_oor", irom_out_of_rst, 0);
    force_ack = 1'b1; idle(); force_ack = 1'b0;
    chk("stray_avail", avail, 0); chk("stray_oor", irom_out_of_rst, 0); chk("stray_istb", istb_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
